// File: rtl/fb_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_pixel_fetch                                                |
// | Purpose  : Framebuffer read stage between the VGA timing generator and   |
// |            the DAC pins. Each visible pixel becomes one read of an       |
// |            RGB444 frame memory. The syncs are delayed by the full        |
// |            pipeline depth so colour, hclk and vclk leave aligned.        |
// | Options  : FB_DOUBLE_BUFFER_EN - when defined, compiles in the           |
// |            front/back buffer swap state machine and front_sel.           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fb_pixel_fetch #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int RD_LATENCY = 1
) (
   input  logic        pixelClk,
   input  logic        reset,
   input  logic        hClkIn,
   input  logic        vClkIn,
   input  logic        hVis,
   input  logic        vVis,
   input  logic [9:0]  xCor,
   input  logic [9:0]  yCor,
   output logic        rd_en,
   output logic [19:0] rd_addr,
   input  logic [11:0] rd_data,
   input  logic        swap_req,
   output logic        swap_ack,
   output logic        front_sel,
   output logic        coord_err,
   output logic        hclk,
   output logic        vclk,
   output logic [3:0]  VGA_R,
   output logic [3:0]  VGA_G,
   output logic [3:0]  VGA_B
);

   // Total latency from coordinate input to colour/sync output: one address
   // register, RD_LATENCY memory cycles, one colour register.
   localparam int          c_PIPE_DEPTH  = RD_LATENCY + 2;
   localparam logic [10:0] c_H_LIMIT     = 11'(H_ACTIVE);
   localparam logic [10:0] c_V_LIMIT     = 11'(V_ACTIVE);
   localparam logic [18:0] c_LINE_STRIDE = 19'(H_ACTIVE);

   logic                    w_frame_vis;
   logic                    w_in_range;
   logic                    w_vis;
   logic                    w_front;
   logic [18:0]             w_pix_idx;
   logic                    w_de_out;

   // r_vis_pipe[0] is the read strobe; the top bit marks the cycle in which
   // the matching memory word is on rd_data.
   logic [c_PIPE_DEPTH-2:0] r_vis_pipe;
   logic [19:0]             r_rd_addr;
   logic [c_PIPE_DEPTH-1:0] r_hs_pipe;
   logic [c_PIPE_DEPTH-1:0] r_vs_pipe;
   logic [c_PIPE_DEPTH-1:0] r_de_pipe;
   logic [11:0]             r_rgb;
   logic                    r_coord_err;

   // ------------------------------------------------------------------------
   // Coordinate qualification and linear pixel index
   // ------------------------------------------------------------------------
   assign w_frame_vis = hVis & vVis;
   assign w_in_range  = ({1'b0, xCor} < c_H_LIMIT) && ({1'b0, yCor} < c_V_LIMIT);
   assign w_vis       = w_frame_vis & w_in_range;

   // Widest legal index is (H_ACTIVE*V_ACTIVE)-1, which fits in 19 bits.
   assign w_pix_idx   = {9'd0, xCor} + (c_LINE_STRIDE * {9'd0, yCor});

   // Stage A: issue one read per qualified pixel and track it down the pipe.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_vis_pipe <= '0;
         r_rd_addr  <= '0;
      end else begin
         r_vis_pipe <= {r_vis_pipe[c_PIPE_DEPTH-3:0], w_vis};
         r_rd_addr  <= {w_front, w_pix_idx};
      end
   end

   assign rd_en   = r_vis_pipe[0];
   assign rd_addr = r_rd_addr;

   // Sync and display-enable delay lines, P stages each, reset to inactive.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_hs_pipe <= '1;
         r_vs_pipe <= '1;
         r_de_pipe <= '0;
      end else begin
         r_hs_pipe <= {r_hs_pipe[c_PIPE_DEPTH-2:0], hClkIn};
         r_vs_pipe <= {r_vs_pipe[c_PIPE_DEPTH-2:0], vClkIn};
         r_de_pipe <= {r_de_pipe[c_PIPE_DEPTH-2:0], w_frame_vis};
      end
   end

   assign hclk     = r_hs_pipe[c_PIPE_DEPTH-1];
   assign vclk     = r_vs_pipe[c_PIPE_DEPTH-1];
   assign w_de_out = r_de_pipe[c_PIPE_DEPTH-1];

   // Stage B: latch the returned word for fetched pixels, black otherwise.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_rgb <= '0;
      end else if (r_vis_pipe[c_PIPE_DEPTH-2]) begin
         r_rgb <= rd_data;
      end else begin
         r_rgb <= '0;
      end
   end

   // The delayed display enable keeps blanking intervals black even if the
   // memory drives stale data.
   assign VGA_R = r_rgb[11:8] & {4{w_de_out}};
   assign VGA_G = r_rgb[7:4]  & {4{w_de_out}};
   assign VGA_B = r_rgb[3:0]  & {4{w_de_out}};

   // Sticky error for visible-flagged coordinates outside the active area.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_coord_err <= 1'b0;
      end else if (w_frame_vis && !w_in_range) begin
         r_coord_err <= 1'b1;
      end
   end

   assign coord_err = r_coord_err;

`ifdef FB_DOUBLE_BUFFER_EN
   // ------------------------------------------------------------------------
   // Front/back buffer swap
   // ------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } swap_state_t;

   swap_state_t             r_state;
   swap_state_t             w_state_nxt;
   logic                    w_boundary;
   logic                    w_do_swap;
   logic                    r_front_sel;
   logic                    r_swap_ack;
   // vVis delayed P cycles plus one more stage for falling-edge detection.
   logic [c_PIPE_DEPTH:0]   r_vv_pipe;

   // Output-side vertical visible flag, used to find the end of each frame.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_vv_pipe <= '0;
      end else begin
         r_vv_pipe <= {r_vv_pipe[c_PIPE_DEPTH-1:0], vVis};
      end
   end

   // Boundary: the delayed flag has just fallen, so the last visible pixel of
   // the frame has left the output and the display is in vertical blank.
   assign w_boundary = r_vv_pipe[c_PIPE_DEPTH] & ~r_vv_pipe[c_PIPE_DEPTH-1];

   // Swap state register.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state: requests collapse into one pending swap per boundary.
   always_comb begin
      w_state_nxt = r_state;
      w_do_swap   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_boundary && swap_req) begin
               w_do_swap = 1'b1;
            end else if (swap_req) begin
               w_state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (w_boundary) begin
               w_do_swap   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Toggle the displayed buffer and acknowledge in the same cycle.
   always_ff @(posedge pixelClk or posedge reset) begin
      if (reset) begin
         r_front_sel <= 1'b0;
         r_swap_ack  <= 1'b0;
      end else begin
         r_swap_ack <= w_do_swap;
         if (w_do_swap) begin
            r_front_sel <= ~r_front_sel;
         end
      end
   end

   assign w_front   = r_front_sel;
   assign front_sel = r_front_sel;
   assign swap_ack  = r_swap_ack;
`else
   // Single-buffer build: everything reads from buffer 0.
   logic w_unused_swap_req;

   assign w_unused_swap_req = swap_req;
   assign w_front           = 1'b0;
   assign front_sel         = 1'b0;
   assign swap_ack          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fb_pixel_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fb_pixel_fetch                                             |
// | Purpose  : Self-checking bench for fb_pixel_fetch at read latencies 1..3 |
// |            against a cycle-history reference model.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fb_pixel_fetch;

   localparam int c_NLAT = 3;
   localparam int c_HIST = 8192;
`ifdef FB_DOUBLE_BUFFER_EN
   localparam bit c_DB = 1'b1;
`else
   localparam bit c_DB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        hs_in, vs_in, hvis, vvis, swap_req;
   logic [9:0]  xc, yc;

   logic        rd_en     [c_NLAT];
   logic [19:0] rd_addr   [c_NLAT];
   logic [11:0] rd_data   [c_NLAT];
   logic        swap_ack  [c_NLAT];
   logic        front_sel [c_NLAT];
   logic        coord_err [c_NLAT];
   logic        hclk      [c_NLAT];
   logic        vclk      [c_NLAT];
   logic [3:0]  vr        [c_NLAT];
   logic [3:0]  vg        [c_NLAT];
   logic [3:0]  vb        [c_NLAT];

   always #5 clk = ~clk;

   // One DUT per read latency, each with its own memory holding addr[11:0].
   for (genvar gi = 0; gi < c_NLAT; gi++) begin : g_lat
      logic [11:0] mem_q [0:2];

      fb_pixel_fetch #(
         .H_ACTIVE   (640),
         .V_ACTIVE   (480),
         .RD_LATENCY (gi + 1)
      ) u_dut (
         .pixelClk  (clk),
         .reset     (rst),
         .hClkIn    (hs_in),
         .vClkIn    (vs_in),
         .hVis      (hvis),
         .vVis      (vvis),
         .xCor      (xc),
         .yCor      (yc),
         .rd_en     (rd_en[gi]),
         .rd_addr   (rd_addr[gi]),
         .rd_data   (rd_data[gi]),
         .swap_req  (swap_req),
         .swap_ack  (swap_ack[gi]),
         .front_sel (front_sel[gi]),
         .coord_err (coord_err[gi]),
         .hclk      (hclk[gi]),
         .vclk      (vclk[gi]),
         .VGA_R     (vr[gi]),
         .VGA_G     (vg[gi]),
         .VGA_B     (vb[gi])
      );

      // Memory returns junk when not read, so unfetched cycles must be blanked.
      always @(posedge clk) begin
         mem_q[0] <= rd_en[gi] ? rd_addr[gi][11:0] : 12'($urandom);
         mem_q[1] <= mem_q[0];
         mem_q[2] <= mem_q[1];
      end
      assign rd_data[gi] = mem_q[gi];
   end

   // Reference model: per-edge history of sampled inputs.
   bit h_hs  [c_HIST];
   bit h_vs  [c_HIST];
   bit h_v   [c_HIST];
   bit h_de  [c_HIST];
   bit h_vis [c_HIST];
   bit h_req [c_HIST];
   int h_idx [c_HIST];
   bit m_front [c_NLAT];
   bit m_pend  [c_NLAT];
   bit m_ack   [c_NLAT];
   bit m_b19   [c_NLAT];
   bit m_cerr;
   int cyc;
   int errors;
   int checks;
   int acks;

   task automatic chk(input string tag, input int lat_i, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s lat=%0d cyc=%0d observed=%h expected=%h",
                tag, lat_i + 1, cyc, obs, exp);
      end
   endtask

   task automatic set_inactive(input int k);
      h_hs[k] = 1'b1; h_vs[k] = 1'b1; h_v[k] = 1'b0;
      h_de[k] = 1'b0; h_vis[k] = 1'b0; h_req[k] = 1'b0; h_idx[k] = 0;
   endtask

   task automatic reset_model();
      for (int k = cyc - 10; k <= cyc; k++) set_inactive(k);
      for (int i = 0; i < c_NLAT; i++) begin
         m_front[i] = 1'b0; m_pend[i] = 1'b0; m_ack[i] = 1'b0;
      end
      m_cerr = 1'b0;
   endtask

   task automatic chk_reset_state(input string tag);
      for (int i = 0; i < c_NLAT; i++) begin
         chk({tag, "_rd_en"}, i, 32'(rd_en[i]), 0);
         chk({tag, "_rd_addr"}, i, 32'(rd_addr[i]), 0);
         chk({tag, "_rgb"}, i, {20'd0, vr[i], vg[i], vb[i]}, 0);
         chk({tag, "_hclk"}, i, 32'(hclk[i]), 1);
         chk({tag, "_vclk"}, i, 32'(vclk[i]), 1);
         chk({tag, "_front"}, i, 32'(front_sel[i]), 0);
         chk({tag, "_ack"}, i, 32'(swap_ack[i]), 0);
         chk({tag, "_cerr"}, i, 32'(coord_err[i]), 0);
      end
   endtask

   // One clock: record inputs, advance the model, then check every DUT.
   task automatic tick();
      int p;
      int j;
      int ec;
      bit bnd;
      @(posedge clk);
      cyc++;
      if (rst) begin
         set_inactive(cyc);
      end else begin
         h_hs[cyc]  = hs_in;
         h_vs[cyc]  = vs_in;
         h_v[cyc]   = vvis;
         h_de[cyc]  = hvis & vvis;
         h_vis[cyc] = hvis && vvis && (int'(xc) < 640) && (int'(yc) < 480);
         h_idx[cyc] = int'(xc) + 640 * int'(yc);
         h_req[cyc] = swap_req;
      end
      if (h_de[cyc] && !h_vis[cyc]) m_cerr = 1'b1;
      for (int i = 0; i < c_NLAT; i++) begin
         p = i + 3;
         m_b19[i] = m_front[i];
         m_ack[i] = 1'b0;
         bnd = !h_v[cyc - p] && h_v[cyc - p - 1];
         if (c_DB) begin
            if (bnd && (m_pend[i] || h_req[cyc])) begin
               m_front[i] = ~m_front[i];
               m_ack[i]   = 1'b1;
               m_pend[i]  = 1'b0;
            end else if (h_req[cyc]) begin
               m_pend[i] = 1'b1;
            end
         end
      end
      #1;
      if (swap_ack[0] === 1'b1) acks++;
      for (int i = 0; i < c_NLAT; i++) begin
         p  = i + 3;
         j  = cyc - p + 1;
         ec = h_vis[j] ? (h_idx[j] % 4096) : 0;
         chk("rd_en", i, 32'(rd_en[i]), 32'(h_vis[cyc]));
         if (h_vis[cyc])
            chk("rd_addr", i, 32'(rd_addr[i]), (m_b19[i] ? 32'h80000 : 32'h0) + h_idx[cyc]);
         chk("rgb", i, {20'd0, vr[i], vg[i], vb[i]}, ec);
         chk("hclk", i, 32'(hclk[i]), 32'(h_hs[j]));
         chk("vclk", i, 32'(vclk[i]), 32'(h_vs[j]));
         chk("front_sel", i, 32'(front_sel[i]), 32'(m_front[i]));
         chk("swap_ack", i, 32'(swap_ack[i]), 32'(m_ack[i]));
         chk("coord_err", i, 32'(coord_err[i]), 32'(m_cerr));
      end
   endtask

   task automatic drive(input bit hs, input bit vs, input bit hv, input bit vv,
                        input int x, input int y, input bit req);
      hs_in = hs; vs_in = vs; hvis = hv; vvis = vv;
      xc = 10'(x); yc = 10'(y); swap_req = req;
      tick();
   endtask

   // Compressed frame: 6 visible lines, 3 blank lines, 22 clocks per line.
   // req_mode: 0 none, 1 two pulses mid-frame, 2 held high, 3 random.
   task automatic frame(input bit inj_err, input int req_mode);
      int ylist [6];
      int xs;
      int x;
      int y;
      bit hv;
      bit vline;
      bit req;
      ylist[0] = 0;
      ylist[1] = 2;
      ylist[2] = int'($urandom_range(3, 239));
      ylist[3] = 240;
      ylist[4] = int'($urandom_range(241, 478));
      ylist[5] = 479;
      for (int l = 0; l < 9; l++) begin
         vline = (l < 6);
         y  = vline ? ylist[l] : 480 + l;
         xs = (l == 1) ? 3 : ((l == 5) ? 624 : int'($urandom_range(0, 624)));
         for (int px = 0; px < 22; px++) begin
            hv = (px < 16);
            x  = hv ? xs + px : 640 + (px - 16) * 50;
            if (inj_err && l == 3 && px == 8) x = 700;
            req = (req_mode == 2) ||
                  (req_mode == 1 && ((l == 1 && px == 4) || (l == 3 && px == 2))) ||
                  (req_mode == 3 && $urandom_range(0, 15) == 0);
            drive(!(px >= 18 && px < 20), !(l == 7), hv, vline, x, y, req);
         end
      end
   endtask

   initial begin
      errors = 0; checks = 0; cyc = 16; acks = 0;
      for (int k = 0; k < c_HIST; k++) set_inactive(k);
      rst = 1'b1; hs_in = 1'b1; vs_in = 1'b1; hvis = 1'b0; vvis = 1'b0;
      xc = '0; yc = '0; swap_req = 1'b0;
      reset_model();
      repeat (3) tick();
      chk_reset_state("reset");
      rst = 1'b0;

      // Pixel (5,2) with a coincident hsync low: colour and sync emerge together.
      drive(1'b0, 1'b1, 1'b1, 1'b1, 5, 2, 1'b0);
      chk("addr_5_2", 0, 32'(rd_addr[0]), 1285);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 600, 2, 1'b0);
      chk("hclk_lag_early", 0, 32'(hclk[0]), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 601, 2, 1'b0);
      chk("rgb_5_2", 0, {20'd0, vr[0], vg[0], vb[0]}, 32'h505);
      chk("hclk_lag3", 0, 32'(hclk[0]), 0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 602, 2, 1'b0);
      chk("rgb_5_2", 1, {20'd0, vr[1], vg[1], vb[1]}, 32'h505);
      chk("hclk_lag4", 1, 32'(hclk[1]), 0);
      chk("rgb_blank", 0, {20'd0, vr[0], vg[0], vb[0]}, 0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 603, 2, 1'b0);
      chk("rgb_5_2", 2, {20'd0, vr[2], vg[2], vb[2]}, 32'h505);
      chk("hclk_lag5", 2, 32'(hclk[2]), 0);
      repeat (20) drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 481, 1'b0);

      frame(1'b0, 0);

      // Two requests in one frame collapse into a single swap.
      acks = 0;
      frame(1'b0, 1);
      chk("swap_ack_count", 0, 32'(acks), 32'(c_DB));
      chk("front_after_swap", 0, 32'(front_sel[0]), 32'(c_DB));
      frame(1'b0, 0);

      // Request held high: one swap per frame.
      for (int n = 0; n < 3; n++) begin
         frame(1'b0, 2);
         chk("front_held", 0, 32'(front_sel[0]), c_DB ? 32'(n % 2) : 32'h0);
      end

      // Out-of-range visible coordinate, random requests.
      frame(1'b1, 3);
      chk("coord_err_set", 0, 32'(coord_err[0]), 1);
      frame(1'b0, 0);
      chk("coord_err_sticky", 0, 32'(coord_err[0]), 1);

      // Reset mid-line at (320,240) with a swap pending.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 316, 240, 1'b1);
      for (int x = 317; x <= 320; x++) drive(1'b1, 1'b1, 1'b1, 1'b1, x, 240, 1'b0);
      rst = 1'b1;
      #1;
      reset_model();
      chk_reset_state("midreset");
      repeat (3) tick();
      rst = 1'b0;
      acks = 0;
      frame(1'b0, 0);
      chk("no_ack_after_reset", 0, 32'(acks), 0);
      chk("front_after_reset", 0, 32'(front_sel[0]), 0);
      chk("cerr_after_reset", 0, 32'(coord_err[0]), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
